xbar_out_port: RTL and testbench
================================

XBAR_OUT_PORT -- requirements
Module: xbar_out_port

Interface
REQ-001 Parameter NUM_INPUTS, default 4: number of upstream stream inputs contending for this crossbar output; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: payload width per beat.
REQ-003 clk_i  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_ni  input  1  synchronous, active-low reset, sampled on rising clk_i.
REQ-005 s_valid_i  input  NUM_INPUTS  per-input beat valid.
REQ-006 s_data_i  input  NUM_INPUTS*DATA_WIDTH  per-input payload; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_last_i  input  NUM_INPUTS  per-input end-of-packet marker.
REQ-008 s_ready_o  output  NUM_INPUTS  per-input beat accept.
REQ-009 req_o  output  NUM_INPUTS  request vector to the fixed-priority arbiter.
REQ-010 grant_i  input  NUM_INPUTS  grant vector returned combinationally by the fixed-priority arbiter.
REQ-011 m_valid_o  output  1  output beat valid (registered).
REQ-012 m_data_o  output  DATA_WIDTH  output payload (registered).
REQ-013 m_last_o  output  1  output end-of-packet (registered).
REQ-014 m_src_o  output  $clog2(NUM_INPUTS)  index of the input that produced the current output beat (registered).
REQ-015 m_ready_i  input  1  downstream accept.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (no owner) and LOCKED (one input owns the output until its packet ends).
REQ-017 In IDLE, req_o SHALL equal s_valid_i; in LOCKED, req_o SHALL be all zeros.
REQ-018 In IDLE, when grant_i is nonzero, the block SHALL register the index of the lowest set bit of grant_i as sel and enter LOCKED on the next cycle; multi-hot grant resolves to the lowest set bit; an all-zero grant keeps IDLE.
REQ-019 In IDLE, s_ready_o SHALL be all zeros; no beat is accepted in the cycle the grant is latched.
REQ-020 In LOCKED, s_ready_o[sel] SHALL equal (!m_valid_o || m_ready_i); all other s_ready_o bits SHALL be 0.
REQ-021 A beat is accepted when s_valid_i[sel] && s_ready_o[sel]; on acceptance, m_valid_o, m_data_o, m_last_o and m_src_o SHALL load the selected input's valid, data, last and sel on the next edge (latency 1 cycle).
REQ-022 When m_valid_o && m_ready_i and no new beat is accepted in the same cycle, m_valid_o SHALL clear; m_data_o, m_last_o and m_src_o hold their values.
REQ-023 Simultaneous output drain and input accept SHALL sustain one beat per cycle with no bubble.
REQ-024 While m_valid_o && !m_ready_i, m_data_o, m_last_o and m_src_o SHALL remain stable.
REQ-025 Accepting a beat with s_last_i[sel]=1 SHALL move the FSM to IDLE on the next cycle, independent of whether the output register has drained.
REQ-026 Deassertion of s_valid_i[sel] mid-packet SHALL NOT release the lock; the FSM stays LOCKED until the last beat is accepted.
REQ-027 A single-beat packet (first beat carries last) SHALL lock and release like any other packet.
REQ-028 Minimum inter-packet turnaround: last beat accepted in cycle t, IDLE in t+1, next owner's first beat accepted no earlier than t+2.
REQ-029 Changes on grant_i while LOCKED SHALL be ignored.

Reset
REQ-030 While rst_ni=0 at a clock edge: FSM=IDLE, sel=0, m_valid_o=0, m_data_o=0, m_last_o=0, m_src_o=0.
REQ-031 Reset asserted mid-packet SHALL discard any held output beat and the lock; s_ready_o and req_o follow the IDLE rules from the first cycle after reset.

Verification (NUM_INPUTS=4, DATA_WIDTH=8, bench drives grant_i as fixed-priority of req_o)
REQ-032 Single owner: input 2 sends 3 beats 0xA0,0xA1,0xA2(last), m_ready_i=1 -> m_data_o sequence A0,A1,A2 on consecutive cycles, m_src_o=2, m_last_o only on A2, then IDLE.
REQ-033 Contention: inputs 1 and 3 valid together -> input 1 packet fully delivered first, then input 3, with exactly one IDLE cycle between packets.
REQ-034 Lock hold: input 3 locked, input 0 asserts valid mid-packet -> s_ready_o[0]=0 and no input-0 beat appears until input 3 last beat accepted.
REQ-035 Backpressure: m_ready_i=0 for 3 cycles mid-packet -> m_data_o stable, s_ready_o[sel]=0, no beat lost or duplicated after m_ready_i returns to 1.
REQ-036 Reset mid-packet: rst_ni=0 for one cycle while m_valid_o=1 and LOCKED -> m_valid_o=0, m_src_o=0, s_ready_o=4'b0000, req_o=s_valid_i next cycle.
REQ-037 Valid gap: owner drops s_valid_i for 2 cycles mid-packet while other inputs request -> req_o=4'b0000 throughout, packet resumes from same owner.

Source files
------------

// File: rtl/xbar_out_port_if.sv
// Stream bundle between contending inputs, the arbiter and one crossbar output.
interface xbar_out_port_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS-1:0]            s_valid_i;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] s_data_i;
    logic [NUM_INPUTS-1:0]            s_last_i;
    logic [NUM_INPUTS-1:0]            s_ready_o;
    logic [NUM_INPUTS-1:0]            req_o;
    logic [NUM_INPUTS-1:0]            grant_i;
    logic                             m_valid_o;
    logic [DATA_WIDTH-1:0]            m_data_o;
    logic                             m_last_o;
    logic [SRC_W-1:0]                 m_src_o;
    logic                             m_ready_i;

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, grant_i, m_ready_i,
        output s_ready_o, req_o, m_valid_o, m_data_o, m_last_o, m_src_o
    );

    modport master (
        output s_valid_i, s_data_i, s_last_i, grant_i, m_ready_i,
        input  s_ready_o, req_o, m_valid_o, m_data_o, m_last_o, m_src_o
    );
endinterface

// File: rtl/xbar_out_port.sv
// Crossbar output port: locks onto one granted input for a whole packet and forwards its beats.
// Latency 1 cycle into a single output register; the owner's ready drops while that register is full and stalled.
module xbar_out_port #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    xbar_out_port_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_INPUTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [SRC_W-1:0]      sel;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [SRC_W-1:0]      m_src;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [SRC_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  out_free;
    logic                  accept;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (sel == SRC_W'(k)) begin
                sel_valid = bus.s_valid_i[k];
                sel_last  = bus.s_last_i[k];
                sel_data  = bus.s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Multi-hot grants collapse to the lowest set bit.
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (bus.grant_i[k]) grant_idx = SRC_W'(k);
        end
    end

    assign grant_any = |bus.grant_i;
    assign out_free  = !m_valid || bus.m_ready_i;
    assign accept    = (state == LOCKED) && sel_valid && out_free;

    always_comb begin
        bus.req_o = (state == IDLE) ? bus.s_valid_i : '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            bus.s_ready_o[k] = (state == LOCKED) && out_free && (sel == SRC_W'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            sel     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel   <= grant_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Release on the last beat even if the output register has not drained yet.
                    if (accept && sel_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= sel_data;
                m_last  <= sel_last;
                m_src   <= sel;
            end else if (m_valid && bus.m_ready_i) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign bus.m_valid_o = m_valid;
    assign bus.m_data_o  = m_data;
    assign bus.m_last_o  = m_last;
    assign bus.m_src_o   = m_src;
endmodule

// File: tb/tb_xbar_out_port.sv
// Randomised packet traffic into xbar_out_port, scoreboarded against a packet-level ownership model.
module tb_xbar_out_port;
    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        int           src;
        logic [W-1:0] d;
        logic         l;
    } obs_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    xbar_out_port_if #(.NUM_INPUTS(N), .DATA_WIDTH(W)) bus ();

    xbar_out_port #(.NUM_INPUTS(N), .DATA_WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Fixed-priority arbiter: lowest requesting index wins.
    always_comb begin
        bus.grant_i = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req_o[k]) begin
                bus.grant_i    = '0;
                bus.grant_i[k] = 1'b1;
            end
        end
    end

    int    vecs = 0;
    int    errs = 0;
    int    cyc = 0;
    int    owner = -1;
    int    gap_pct = 0;
    int    stall_pct = 0;
    int    force_stall = 0;
    beat_t src_q [N][$];
    obs_t  exp_q [$];
    int    fire_cyc [$];
    int    fire_src [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit all_done();
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
        return (exp_q.size() == 0) && (owner < 0);
    endfunction

    // Monitor: whatever sits in the output register must be the oldest accepted beat.
    always @(negedge clk_i) begin
        #1;
        check("m_valid", 32'(bus.m_valid_o), 32'(exp_q.size() != 0));
        if (bus.m_valid_o && exp_q.size() != 0) begin
            check("m_src",  32'(bus.m_src_o),  32'(exp_q[0].src));
            check("m_data", 32'(bus.m_data_o), 32'(exp_q[0].d));
            check("m_last", 32'(bus.m_last_o), 32'(exp_q[0].l));
            if (bus.m_ready_i) begin
                fire_cyc.push_back(cyc);
                fire_src.push_back(int'(bus.m_src_o));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic rst_val);
        logic [N-1:0]   sv;
        logic [N*W-1:0] sd;
        logic [N-1:0]   sl;
        logic [N-1:0]   exp_req;
        logic [N-1:0]   exp_rdy;
        @(negedge clk_i);
        cyc++;
        rst_ni = rst_val;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0 && $urandom_range(99) >= gap_pct) begin
                sv[k]         = 1'b1;
                sd[k*W +: W]  = src_q[k][0].d;
                sl[k]         = src_q[k][0].l;
            end else begin
                sv[k]         = 1'b0;
                sd[k*W +: W]  = W'($urandom);
                sl[k]         = 1'($urandom);
            end
        end
        bus.s_valid_i = sv;
        bus.s_data_i  = sd;
        bus.s_last_i  = sl;
        if (force_stall > 0) begin
            bus.m_ready_i = 1'b0;
            force_stall--;
        end else begin
            bus.m_ready_i = ($urandom_range(99) >= stall_pct);
        end
        #2;
        exp_req = (owner < 0) ? sv : '0;
        exp_rdy = '0;
        if (owner >= 0 && (!bus.m_valid_o || bus.m_ready_i)) exp_rdy[owner] = 1'b1;
        check("req", 32'(bus.req_o), 32'(exp_req));
        check("s_ready", 32'(bus.s_ready_o), 32'(exp_rdy));
        if (!rst_val) begin
            owner = -1;
            exp_q.delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sv[k] && bus.s_ready_o[k]) begin
                    exp_q.push_back('{src: k, d: sd[k*W +: W], l: sl[k]});
                    void'(src_q[k].pop_front());
                end
            end
            if (owner < 0) begin
                if (|sv) owner = lowest(sv);
            end else if (sv[owner] && bus.s_ready_o[owner] && sl[owner]) begin
                owner = -1;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (!all_done() && n < bound) begin
            step(1'b1);
            n++;
        end
        vecs++;
        if (n >= bound) begin
            errs++;
            $display("FAIL drain_timeout at cycle %0d: still busy after %0d cycles, expected idle", cyc, n);
        end
    endtask

    task automatic add_pkt(input int k, input int len, input logic [W-1:0] base);
        for (int i = 0; i < len; i++) src_q[k].push_back('{d: base + W'(i), l: (i == len - 1)});
    endtask

    task automatic check_order(input string name, input int exp_len, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
        int e [5];
        e = '{e0, e1, e2, e3, e4};
        check({name, "_count"}, 32'(fire_src.size()), 32'(exp_len));
        for (int i = 0; i < exp_len && i < fire_src.size(); i++) check({name, "_src"}, 32'(fire_src[i]), 32'(e[i]));
    endtask

    initial begin
        bus.s_valid_i = '0;
        bus.s_data_i  = '0;
        bus.s_last_i  = '0;
        bus.m_ready_i = 1'b1;

        step(1'b0);
        step(1'b0);
        @(posedge clk_i); #1;
        check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("rst_m_data",  32'(bus.m_data_o),  32'd0);
        check("rst_m_last",  32'(bus.m_last_o),  32'd0);
        check("rst_m_src",   32'(bus.m_src_o),   32'd0);
        check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);

        // Single owner, three beats back to back.
        fire_cyc.delete(); fire_src.delete();
        add_pkt(2, 3, 8'hA0);
        drain(50);
        check_order("single", 3, 2, 2, 2, 0, 0);
        if (fire_cyc.size() == 3) begin
            check("single_gap01", 32'(fire_cyc[1] - fire_cyc[0]), 32'd1);
            check("single_gap12", 32'(fire_cyc[2] - fire_cyc[1]), 32'd1);
        end

        // Contention: lower index first, one idle turnaround cycle between packets.
        fire_cyc.delete(); fire_src.delete();
        add_pkt(1, 2, 8'hB0);
        add_pkt(3, 2, 8'hC0);
        drain(50);
        check_order("contend", 4, 1, 1, 3, 3, 0);
        if (fire_cyc.size() == 4) check("contend_turn", 32'(fire_cyc[2] - fire_cyc[1]), 32'd2);

        // Lock hold: input 0 arrives while input 3 owns the port.
        fire_cyc.delete(); fire_src.delete();
        add_pkt(3, 4, 8'hD0);
        step(1'b1);
        step(1'b1);
        add_pkt(0, 1, 8'hE0);
        drain(50);
        check_order("lock_hold", 5, 3, 3, 3, 3, 0);

        // Backpressure mid-packet.
        fire_cyc.delete(); fire_src.delete();
        add_pkt(1, 4, 8'h10);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        force_stall = 3;
        drain(50);
        check_order("backpress", 4, 1, 1, 1, 1, 0);

        // Reset while locked with a beat held in the output register.
        add_pkt(1, 4, 8'h20);
        step(1'b1);
        step(1'b1);
        force_stall = 2;
        step(1'b1);
        step(1'b0);
        @(posedge clk_i); #1;
        check("rstmid_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("rstmid_m_src",   32'(bus.m_src_o),   32'd0);
        check("rstmid_s_ready", 32'(bus.s_ready_o), 32'd0);
        check("rstmid_req",     32'(bus.req_o),     32'(bus.s_valid_i));
        drain(100);

        // Random traffic with valid gaps and output stalls.
        for (int round = 0; round < 2; round++) begin
            gap_pct   = (round == 0) ? 25 : 50;
            stall_pct = (round == 0) ? 30 : 60;
            for (int k = 0; k < N; k++) begin
                int npk;
                npk = $urandom_range(5, 2);
                for (int p = 0; p < npk; p++) add_pkt(k, $urandom_range(4, 1), W'($urandom));
            end
            drain(5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
